// File: rtl/traffic_sched.sv
// Two-way traffic-light scheduler with pedestrian walk phase, night flashing
// mode and emergency all-red override. Timing is counted in 1-second ticks
// derived from clk by a prescaler; all lamps are decoded from the registered
// state, the phase counter and the night flash bit.
module traffic_sched #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_T  = 9,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned WALK_T   = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ped_req,
  input  logic       night,
  input  logic       emerg,
  output logic [5:0] lights,
  output logic [3:0] counter,
  output logic       walk,
  output logic       ped_ack
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  // Lamp patterns: [5:3] direction A {R,Y,G}, [2:0] direction B {R,Y,G}
  localparam logic [5:0] L_AG    = 6'b001100;
  localparam logic [5:0] L_AY    = 6'b010100;
  localparam logic [5:0] L_BG    = 6'b100001;
  localparam logic [5:0] L_BY    = 6'b100010;
  localparam logic [5:0] L_RED   = 6'b100100;
  localparam logic [5:0] L_FLASH = 6'b010010;

  typedef enum logic [2:0] {
    S_AG, S_AY, S_BG, S_BY, S_WALK, S_CLEAR, S_NIGHT, S_EMERG
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_q, sec_d;
  logic          pend_q, pend_d;
  logic          flash_q, flash_d;
  logic          tick;
  logic [3:0]    dur;

  // Phase length in ticks; untimed states report zero
  function automatic logic [3:0] phase_dur(input state_t s);
    case (s)
      S_AG, S_BG:             phase_dur = 4'(GREEN_T);
      S_AY, S_BY, S_CLEAR:    phase_dur = 4'(YELLOW_T);
      S_WALK:                 phase_dur = 4'(WALK_T);
      default:                phase_dur = 4'd0;
    endcase
  endfunction

  assign tick = (pre_q == PW'(TICK_DIV - 1));
  assign dur  = phase_dur(state_q);

  // Next-state logic: emergency overrides everything, then tick-driven phase
  // sequencing; yellow ends are the only points where night mode may begin.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    pre_d   = tick ? '0 : pre_q + PW'(1);
    flash_d = flash_q;
    pend_d  = pend_q | ped_req;
    if (emerg) begin
      state_d = S_EMERG;
      pre_d   = '0;
      sec_d   = '0;
    end else if (state_q == S_EMERG) begin
      state_d = S_AG;
      pre_d   = '0;
      sec_d   = '0;
    end else if (tick) begin
      if (state_q == S_NIGHT) begin
        if (!night) begin
          state_d = S_CLEAR;
          sec_d   = '0;
        end else begin
          flash_d = ~flash_q;
        end
      end else if (sec_q == dur - 4'd1) begin
        sec_d = '0;
        case (state_q)
          S_AG:    state_d = S_AY;
          S_AY:    state_d = night ? S_NIGHT : S_BG;
          S_BG:    state_d = S_BY;
          S_BY:    state_d = night ? S_NIGHT : (pend_q ? S_WALK : S_AG);
          default: state_d = S_AG;
        endcase
      end else begin
        sec_d = sec_q + 4'd1;
      end
    end
    // A fresh night phase always starts on the lit half of the flash cycle
    if (state_d != state_q) flash_d = 1'b0;
    // Entering WALK consumes the request, even one arriving on that clk
    if (state_d == S_WALK && state_q != S_WALK) pend_d = 1'b0;
  end

  // State, prescaler, phase counter, pending request and flash registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_AG;
      pre_q   <= '0;
      sec_q   <= '0;
      pend_q  <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      pend_q  <= pend_d;
      flash_q <= flash_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    lights  = L_RED;
    walk    = 1'b0;
    counter = dur - sec_q;
    case (state_q)
      S_AG:    lights = L_AG;
      S_AY:    lights = L_AY;
      S_BG:    lights = L_BG;
      S_BY:    lights = L_BY;
      S_WALK: begin
        lights = L_RED;
        walk   = 1'b1;
      end
      S_CLEAR: lights = L_RED;
      S_NIGHT: begin
        lights  = flash_q ? 6'b000000 : L_FLASH;
        counter = 4'd0;
      end
      default: begin
        lights  = L_RED;
        counter = 4'd0;
      end
    endcase
  end

  assign ped_ack = pend_q;

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench for traffic_sched with a 4-clk tick. Each scenario pushes
// the per-clk expected {lights, counter, walk, ped_ack} sequence, then steps
// the clock and compares one entry per falling edge.
module tb_traffic_sched;

  localparam int TD = 4;

  localparam logic [5:0] LAG  = 6'b001100;
  localparam logic [5:0] LAY  = 6'b010100;
  localparam logic [5:0] LBG  = 6'b100001;
  localparam logic [5:0] LBY  = 6'b100010;
  localparam logic [5:0] LRR  = 6'b100100;
  localparam logic [5:0] LFL  = 6'b010010;
  localparam logic [5:0] LOFF = 6'b000000;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic       emerg = 1'b0;
  logic [5:0] lights;
  logic [3:0] counter;
  logic       walk;
  logic       ped_ack;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb[$];

  traffic_sched #(.TICK_DIV(TD), .GREEN_T(9), .YELLOW_T(3), .WALK_T(5)) dut (
    .clk(clk), .clr(clr), .ped_req(ped_req), .night(night), .emerg(emerg),
    .lights(lights), .counter(counter), .walk(walk), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  // n clk samples of a timed phase; ped_ack expected 1 from sample ack_from on
  task automatic push_phase(input logic [5:0] l, input logic w, input int ack_from,
                            input int dur, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back({l, 4'(dur - i / TD), w, (i >= ack_from)});
  endtask

  task automatic push_n(input logic [5:0] l, input logic [3:0] c, input logic w,
                        input logic a, input int n);
    for (int i = 0; i < n; i++) sb.push_back({l, c, w, a});
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] exp, got;
    #3 clr = 1'b1;
    #1;
    got = {lights, counter, walk, ped_ack};
    checks++;
    if (got !== {LAG, 4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async actual=%h expected=%h", got, {LAG, 4'd9, 1'b0, 1'b0});
    end
    ped_req = 1'b1;
    push_n(LAG, 4'd9, 1'b0, 1'b0, 3);
    @(negedge clk);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_hold actual=%h expected=%h", got, exp);
      end
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_idle_cycle();
    logic [11:0] exp, got;
    int k;
    do_reset();
    push_phase(LAG, 1'b0, 999, 9, 36);
    push_phase(LAY, 1'b0, 999, 3, 12);
    push_phase(LBG, 1'b0, 999, 9, 36);
    push_phase(LBY, 1'b0, 999, 3, 12);
    push_phase(LAG, 1'b0, 999, 9, 4);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL idle k=%0d actual=%h expected=%h", k, got, exp);
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_ped_walk_reset();
    logic [11:0] exp, got;
    int k;
    do_reset();
    push_phase(LAG, 1'b0, 6, 9, 36);
    push_phase(LAY, 1'b0, 0, 3, 12);
    push_phase(LBG, 1'b0, 0, 9, 36);
    push_phase(LBY, 1'b0, 0, 3, 12);
    push_phase(LRR, 1'b1, 999, 5, 4);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ped k=%0d actual=%h expected=%h", k, got, exp);
      end
      ped_req = (k == 5);
      @(negedge clk);
      k++;
    end
    clr = 1'b1;
    #1;
    got = {lights, counter, walk, ped_ack};
    checks++;
    if (got !== {LAG, 4'd9, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_walk actual=%h expected=%h", got, {LAG, 4'd9, 1'b0, 1'b0});
    end
    @(negedge clk);
    clr = 1'b0;
    push_phase(LAG, 1'b0, 999, 9, 8);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_reset actual=%h expected=%h", got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_emerg();
    logic [11:0] exp, got;
    int k;
    do_reset();
    push_phase(LAG, 1'b0, 999, 9, 36);
    push_phase(LAY, 1'b0, 999, 3, 12);
    push_phase(LBG, 1'b0, 999, 9, 13);
    push_n(LRR, 4'd0, 1'b0, 1'b0, 3);
    push_n(LRR, 4'd0, 1'b0, 1'b1, 7);
    push_phase(LAG, 1'b0, 0, 9, 36);
    push_phase(LAY, 1'b0, 0, 3, 4);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL emerg k=%0d actual=%h expected=%h", k, got, exp);
      end
      emerg   = (k >= 60 && k < 70);
      ped_req = (k == 63);
      @(negedge clk);
      k++;
    end
    emerg = 1'b0;
    ped_req = 1'b0;
  endtask

  task automatic test_night();
    logic [11:0] exp, got;
    int k;
    do_reset();
    push_phase(LAG, 1'b0, 999, 9, 36);
    push_phase(LAY, 1'b0, 999, 3, 12);
    for (int p = 0; p < 6; p++)
      push_n((p % 2 == 0) ? LFL : LOFF, 4'd0, 1'b0, 1'b0, TD);
    push_phase(LRR, 1'b0, 999, 3, 12);
    push_phase(LAG, 1'b0, 999, 9, 4);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL night k=%0d actual=%h expected=%h", k, got, exp);
      end
      night = (k >= 10 && k < 69);
      @(negedge clk);
      k++;
    end
    night = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp, got;
    int k;
    do_reset();
    push_phase(LAG, 1'b0, 6, 9, 36);
    push_phase(LAY, 1'b0, 0, 3, 12);
    push_phase(LBG, 1'b0, 0, 9, 36);
    push_phase(LBY, 1'b0, 0, 3, 12);
    push_n(LFL, 4'd0, 1'b0, 1'b1, TD);
    push_n(LOFF, 4'd0, 1'b0, 1'b1, TD);
    push_phase(LRR, 1'b0, 0, 3, 12);
    push_phase(LAG, 1'b0, 0, 9, 36);
    push_phase(LAY, 1'b0, 0, 3, 12);
    push_phase(LBG, 1'b0, 0, 9, 36);
    push_phase(LBY, 1'b0, 0, 3, 12);
    push_phase(LRR, 1'b1, 999, 5, 20);
    push_phase(LAG, 1'b0, 999, 9, 4);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      got = {lights, counter, walk, ped_ack};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL simul k=%0d actual=%h expected=%h", k, got, exp);
      end
      ped_req = (k == 5);
      night   = (k >= 85 && k < 100);
      @(negedge clk);
      k++;
    end
    ped_req = 1'b0;
    night = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_cycle();
    test_ped_walk_reset();
    test_emerg();
    test_night();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_sched.md
TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- TICK_DIV, 50000000, clk cycles per 1-second tick
- GREEN_T, 9, green duration in ticks
- YELLOW_T, 3, yellow duration in ticks
- WALK_T, 5, pedestrian walk duration in ticks
REQ-002 Parameter range SHALL be GREEN_T, YELLOW_T and WALK_T each 1..15, and TICK_DIV >= 2.
REQ-003 The block SHALL provide these ports (name, direction, width, meaning):
- clk, in, 1, clock
- clr, in, 1, reset: asynchronous, active-high
- ped_req, in, 1, pedestrian button, sampled every clk
- night, in, 1, night-mode request (level)
- emerg, in, 1, emergency all-red request (level)
- lights, out, 6, [5:3] = direction A {R,Y,G}; [2:0] = direction B {R,Y,G}
- counter, out, 4, remaining ticks in current phase
- walk, out, 1, pedestrian walk lamp
- ped_ack, out, 1, pedestrian request registered

Function
REQ-004 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick for one clk when it equals TICK_DIV-1.
REQ-005 The phase counter sec SHALL clear on every state change and otherwise increment on tick.
REQ-006 A timed state SHALL be left on the tick where sec == duration-1, so that each state lasts exactly duration ticks.
REQ-007 The block SHALL implement these states (lights, walk, duration):
- A_G: 001100, walk 0, GREEN_T
- A_Y: 010100, walk 0, YELLOW_T
- B_G: 100001, walk 0, GREEN_T
- B_Y: 100010, walk 0, YELLOW_T
- WALK: 100100, walk 1, WALK_T
- CLEAR: 100100, walk 0, YELLOW_T
- NIGHT: untimed
- EMERG: untimed
REQ-008 Normal timed transitions SHALL be:
- A_G->A_Y
- A_Y->B_G
- B_G->B_Y
- B_Y->WALK if ped_pend, else A_G
- WALK->A_G
- CLEAR->A_G
REQ-009 At the end of A_Y or B_Y, if night=1 the next state SHALL be NIGHT, taking priority over ped_pend and the normal successor.
REQ-010 Night mode SHALL enter only at these yellow-end points; night asserted in any other state SHALL take effect at the next such point.
REQ-011 In NIGHT, lights SHALL alternate on each tick, starting with 010010 for the first tick period and then 000000.
REQ-012 In NIGHT, counter SHALL be 0 and walk SHALL be 0.
REQ-013 On a tick while in NIGHT with night=0, the state SHALL go to CLEAR.
REQ-014 emerg=1 SHALL force EMERG on the next clk from any state, and SHALL also clear the prescaler and sec.
REQ-015 In EMERG, lights SHALL be 100100, walk 0, counter 0, and the state SHALL hold while emerg=1.
REQ-016 On the first clk with emerg=0 in EMERG, the state SHALL go to A_G with the prescaler and sec cleared.
REQ-017 Priority SHALL be emerg > night > ped_pend.
REQ-018 ped_pend SHALL set on any clk with ped_req=1 and clear on the clk that enters WALK.
REQ-019 If ped_req=1 on the same clk that enters WALK, the clear SHALL win.
REQ-020 ped_pend SHALL be retained through NIGHT and EMERG.
REQ-021 ped_ack SHALL equal ped_pend (registered, one clk after ped_req).
REQ-022 In timed states, counter SHALL equal duration - sec, decrementing from duration to 1.
REQ-023 lights, counter and walk SHALL be decoded combinationally from the registered state, sec and flash bit.

Reset
REQ-024 While clr=1, the following SHALL be forced immediately, independent of clk:
- state A_G
- prescaler 0, sec 0
- ped_pend 0, flash bit 0
REQ-025 The resulting reset outputs SHALL be lights=001100, counter=GREEN_T, walk=0, ped_ack=0.
REQ-026 clr asserted mid-operation (including WALK, NIGHT, EMERG) SHALL abandon the current phase with no completion.
REQ-027 After clr deasserts, the first tick SHALL occur TICK_DIV clk later.

Verification (TICK_DIV=4, defaults otherwise)
REQ-028 Idle cycle: release clr, all inputs 0 -> A_G 36 clk (counter 9..1), A_Y 12, B_G 36, B_Y 12, then A_G again; period 96 clk.
REQ-029 Pedestrian: 1-clk ped_req pulse in A_G -> ped_ack=1 next clk; after B_Y, WALK with lights=100100, walk=1, counter 5..1, ped_ack=0 on entry; then A_G.
REQ-030 Emergency: emerg=1 mid B_G -> next clk lights=100100, counter=0; hold 10 clk; release -> A_G, counter=9, first tick 4 clk later.
REQ-031 Night: night=1 during A_G -> A_G and A_Y complete; then lights alternate 010010/000000 every 4 clk; night=0 -> CLEAR for 12 clk, then A_G.
REQ-032 Simultaneous events: ped_pend=1 and night=1 at end of B_Y -> NIGHT entered, ped_ack stays 1; WALK occurs only after a later B_Y with night=0.
REQ-033 Reset mid-WALK: clr pulse -> same clk lights=001100, walk=0, ped_ack=0, counter=9.
